falafel_req_arbiter: RTL and testbench
======================================

FALAFEL_REQ_ARBITER -- requirements
Module: falafel_req_arbiter

Interface
REQ-001 Parameters: NUM_PORTS, default 2, number of client ports (2..8); FIFO_DEPTH, default 4, entries per client request FIFO (power of 2, >=2).
REQ-002 The block SHALL be clocked by one clock and reset asynchronously, active-high. Ports:
  clk_i  in  1  clock
  rst_i  in  1  asynchronous active-high reset
  port_req_valid_i  in  NUM_PORTS  per-client request valid
  port_req_ready_o  out  NUM_PORTS  per-client FIFO not full
  port_req_is_alloc_i  in  NUM_PORTS  1 alloc, 0 free
  port_req_data_i  in  NUM_PORTS x DATA_W  size to allocate, or address to free
  port_rsp_valid_o  out  NUM_PORTS  one-hot result valid
  port_rsp_ready_i  in  NUM_PORTS  per-client result ready
  port_rsp_is_write_o  out  1  result is_write flag (shared)
  port_rsp_data_o  out  DATA_W  result data (shared)
  alloc_req_valid_o  out  1  request valid to allocator core
  alloc_req_ready_i  in  1  allocator ready
  alloc_is_alloc_o  out  1  alloc/free select
  alloc_addr_to_free_o  out  DATA_W  free address
  alloc_size_to_allocate_o  out  DATA_W  alloc size
  alloc_rsp_val_i  in  1  allocator result valid
  alloc_rsp_is_write_i  in  1  allocator result is_write
  alloc_rsp_data_i  in  DATA_W  allocator result data
  alloc_rsp_ready_o  out  1  arbiter ready for result

Function
REQ-003 Each port SHALL own a FIFO of FIFO_DEPTH entries {is_alloc, data}; push on port_req_valid_i & port_req_ready_o; port_req_ready_o = not full (no combinational dependence on pop).
REQ-004 Full FIFO with simultaneous pop SHALL still deassert ready that cycle; push and pop in same cycle on a non-full, non-empty FIFO SHALL keep occupancy unchanged.
REQ-005 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-006 FSM states IDLE, ISSUE, WAIT_RSP, RETURN; exactly one request outstanding to the allocator at any time.
REQ-007 IDLE: if any FIFO non-empty, grant by round-robin starting at (last_grant+1) mod NUM_PORTS, pop granted head into holding register, record grant index, go ISSUE; else stay.
REQ-008 ISSUE: alloc_req_valid_o=1, outputs stable until alloc_req_ready_i; on handshake go WAIT_RSP.
REQ-009 alloc_size_to_allocate_o = data when is_alloc else 0; alloc_addr_to_free_o = data when free else 0.
REQ-010 WAIT_RSP: alloc_rsp_ready_o=1; on alloc_rsp_val_i capture is_write and data, go RETURN.
REQ-011 RETURN: port_rsp_valid_o one-hot at grant index, data/is_write stable until port_rsp_ready_i of that port; then update last_grant, go IDLE.
REQ-012 Minimum latency: push at cycle t -> alloc_req_valid_o at t+2; allocator response at cycle r -> port_rsp_valid_o at r+1.
REQ-013 port_rsp_ready_i of non-granted ports SHALL be ignored; alloc_rsp_val_i outside WAIT_RSP SHALL be ignored.
REQ-014 Outputs not named active in a state SHALL be 0.

Reset
REQ-015 On rst_i: FSM=IDLE, FIFOs empty, last_grant=NUM_PORTS-1 (port 0 first), all valid/ready outputs 0 except port_req_ready_o which SHALL read all-ones after reset release, data outputs 0.
REQ-016 Reset mid-operation SHALL drop queued and in-flight requests without any response; allocator core is reset on the same reset.

Structure
REQ-017 DATA_W and the FSM state enum (arb_state_t) SHALL live in falafel_pkg; request entry struct arb_req_t {is_alloc, data} also in falafel_pkg.
REQ-018 One sub-module falafel_req_fifo (parameterised depth/width), instantiated NUM_PORTS times.

Verification
REQ-019 Single alloc: port0 size 0x40 -> alloc_req_valid_o 2 cycles later, size=0x40, addr=0; allocator returns 0x1000 -> port_rsp_valid_o=01, data 0x1000.
REQ-020 Both ports request same cycle (port0 alloc 0x10, port1 free 0x2000) -> port0 issued first, port1 second with addr=0x2000, size=0.
REQ-021 Fill port1 with 4 requests, no allocator ready -> port_req_ready_o[1]=0 after 4th push; 5th not accepted; all 4 later served in order.
REQ-022 Backpressure: alloc_req_ready_i low 5 cycles, port_rsp_ready_i low 3 cycles -> outputs held stable, no duplicate issue or response.
REQ-023 rst_i asserted in WAIT_RSP with 2 queued entries -> all outputs at reset values next edge-independent, no response delivered, queues empty.

Source files
------------

// File: rtl/falafel_pkg.sv
// rtl/falafel_pkg.sv - shared types and constants for the falafel request arbiter
package falafel_pkg;

    // Width of allocation sizes, free addresses and allocator results.
    localparam int DATA_W = 32;

    // Arbiter sequencing: one request in flight to the allocator core at a time.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_RETURN   = 2'd3
    } arb_state_t;

    // One queued client request: alloc (data = size) or free (data = address).
    typedef struct packed {
        logic              is_alloc;
        logic [DATA_W-1:0] data;
    } arb_req_t;

    // Port index visited at round-robin offset 'off' after 'last'.
    function automatic int rr_index(input int last, input int off, input int n);
        return (last + off) % n;
    endfunction

endpackage

// File: rtl/falafel_req_fifo.sv
// rtl/falafel_req_fifo.sv - per-client request FIFO with registered full/empty
module falafel_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Full/empty come only from the stored count, so ready never depends on a same-cycle pop.
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign pop_data_o = mem_q[rd_ptr_q];
    assign do_push    = push_i & ~full_o;
    assign do_pop     = pop_i & ~empty_o;

    // Next-state for storage, pointers (wrap by natural overflow) and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset empties the queue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/falafel_req_arbiter.sv
// rtl/falafel_req_arbiter.sv - round-robin arbiter of client alloc/free requests onto one allocator core
module falafel_req_arbiter
    import falafel_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_PORTS-1:0]        port_req_valid_i,
    output logic [NUM_PORTS-1:0]        port_req_ready_o,
    input  logic [NUM_PORTS-1:0]        port_req_is_alloc_i,
    input  logic [NUM_PORTS*DATA_W-1:0] port_req_data_i,
    output logic [NUM_PORTS-1:0]        port_rsp_valid_o,
    input  logic [NUM_PORTS-1:0]        port_rsp_ready_i,
    output logic                        port_rsp_is_write_o,
    output logic [DATA_W-1:0]           port_rsp_data_o,
    output logic                        alloc_req_valid_o,
    input  logic                        alloc_req_ready_i,
    output logic                        alloc_is_alloc_o,
    output logic [DATA_W-1:0]           alloc_addr_to_free_o,
    output logic [DATA_W-1:0]           alloc_size_to_allocate_o,
    input  logic                        alloc_rsp_val_i,
    input  logic                        alloc_rsp_is_write_i,
    input  logic [DATA_W-1:0]           alloc_rsp_data_i,
    output logic                        alloc_rsp_ready_o
);

    localparam int GW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int REQ_W = $bits(arb_req_t);

    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] fifo_push;
    logic [NUM_PORTS-1:0] fifo_pop;
    arb_req_t             fifo_wdata [NUM_PORTS];
    arb_req_t             fifo_head  [NUM_PORTS];

    arb_state_t           state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        last_grant_q, last_grant_d;
    logic                 alloc_req_valid_q, alloc_req_valid_d;
    logic                 alloc_is_alloc_q, alloc_is_alloc_d;
    logic [DATA_W-1:0]    alloc_size_q, alloc_size_d;
    logic [DATA_W-1:0]    alloc_addr_q, alloc_addr_d;
    logic                 alloc_rsp_ready_q, alloc_rsp_ready_d;
    logic [NUM_PORTS-1:0] port_rsp_valid_q, port_rsp_valid_d;
    logic                 port_rsp_is_write_q, port_rsp_is_write_d;
    logic [DATA_W-1:0]    port_rsp_data_q, port_rsp_data_d;

    logic                 rr_found;
    logic [GW-1:0]        rr_idx;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        assign fifo_wdata[g] = '{is_alloc: port_req_is_alloc_i[g],
                                 data:     port_req_data_i[g*DATA_W +: DATA_W]};
        assign fifo_push[g]  = port_req_valid_i[g] & ~fifo_full[g];

        falafel_req_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (REQ_W)
        ) u_fifo (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .push_i      (fifo_push[g]),
            .push_data_i (fifo_wdata[g]),
            .pop_i       (fifo_pop[g]),
            .pop_data_o  (fifo_head[g]),
            .full_o      (fifo_full[g]),
            .empty_o     (fifo_empty[g])
        );
    end

    assign port_req_ready_o         = ~fifo_full;
    assign port_rsp_valid_o         = port_rsp_valid_q;
    assign port_rsp_is_write_o      = port_rsp_is_write_q;
    assign port_rsp_data_o          = port_rsp_data_q;
    assign alloc_req_valid_o        = alloc_req_valid_q;
    assign alloc_is_alloc_o         = alloc_is_alloc_q;
    assign alloc_size_to_allocate_o = alloc_size_q;
    assign alloc_addr_to_free_o     = alloc_addr_q;
    assign alloc_rsp_ready_o        = alloc_rsp_ready_q;

    // Round-robin pick: first non-empty port starting one past the last served port.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            if (!rr_found && !fifo_empty[rr_index(int'(last_grant_q), off, NUM_PORTS)]) begin
                rr_found = 1'b1;
                rr_idx   = GW'(rr_index(int'(last_grant_q), off, NUM_PORTS));
            end
        end
    end

    // FSM next-state and next values of every registered output; inactive outputs return to 0.
    always_comb begin
        state_d             = state_q;
        grant_d             = grant_q;
        last_grant_d        = last_grant_q;
        alloc_req_valid_d   = alloc_req_valid_q;
        alloc_is_alloc_d    = alloc_is_alloc_q;
        alloc_size_d        = alloc_size_q;
        alloc_addr_d        = alloc_addr_q;
        alloc_rsp_ready_d   = alloc_rsp_ready_q;
        port_rsp_valid_d    = port_rsp_valid_q;
        port_rsp_is_write_d = port_rsp_is_write_q;
        port_rsp_data_d     = port_rsp_data_q;
        fifo_pop            = '0;

        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    fifo_pop[rr_idx]  = 1'b1;
                    grant_d           = rr_idx;
                    alloc_req_valid_d = 1'b1;
                    alloc_is_alloc_d  = fifo_head[rr_idx].is_alloc;
                    alloc_size_d      = fifo_head[rr_idx].is_alloc ? fifo_head[rr_idx].data : '0;
                    alloc_addr_d      = fifo_head[rr_idx].is_alloc ? '0 : fifo_head[rr_idx].data;
                    state_d           = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (alloc_req_ready_i) begin
                    alloc_req_valid_d = 1'b0;
                    alloc_is_alloc_d  = 1'b0;
                    alloc_size_d      = '0;
                    alloc_addr_d      = '0;
                    alloc_rsp_ready_d = 1'b1;
                    state_d           = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (alloc_rsp_val_i) begin
                    alloc_rsp_ready_d         = 1'b0;
                    port_rsp_valid_d          = '0;
                    port_rsp_valid_d[grant_q] = 1'b1;
                    port_rsp_is_write_d       = alloc_rsp_is_write_i;
                    port_rsp_data_d           = alloc_rsp_data_i;
                    state_d                   = ST_RETURN;
                end
            end
            ST_RETURN: begin
                if (port_rsp_ready_i[grant_q]) begin
                    port_rsp_valid_d    = '0;
                    port_rsp_is_write_d = 1'b0;
                    port_rsp_data_d     = '0;
                    last_grant_d        = grant_q;
                    state_d             = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs; reset drops any in-flight request silently.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q             <= ST_IDLE;
            grant_q             <= '0;
            last_grant_q        <= GW'(NUM_PORTS - 1);
            alloc_req_valid_q   <= 1'b0;
            alloc_is_alloc_q    <= 1'b0;
            alloc_size_q        <= '0;
            alloc_addr_q        <= '0;
            alloc_rsp_ready_q   <= 1'b0;
            port_rsp_valid_q    <= '0;
            port_rsp_is_write_q <= 1'b0;
            port_rsp_data_q     <= '0;
        end else begin
            state_q             <= state_d;
            grant_q             <= grant_d;
            last_grant_q        <= last_grant_d;
            alloc_req_valid_q   <= alloc_req_valid_d;
            alloc_is_alloc_q    <= alloc_is_alloc_d;
            alloc_size_q        <= alloc_size_d;
            alloc_addr_q        <= alloc_addr_d;
            alloc_rsp_ready_q   <= alloc_rsp_ready_d;
            port_rsp_valid_q    <= port_rsp_valid_d;
            port_rsp_is_write_q <= port_rsp_is_write_d;
            port_rsp_data_q     <= port_rsp_data_d;
        end
    end

endmodule

// File: tb/tb_falafel_req_arbiter.sv
// tb/tb_falafel_req_arbiter.sv - directed self-checking bench for falafel_req_arbiter
module tb_falafel_req_arbiter;

    logic        clk;
    logic        rst_i;
    logic [1:0]  port_req_valid_i;
    logic [1:0]  port_req_ready_o;
    logic [1:0]  port_req_is_alloc_i;
    logic [63:0] port_req_data_i;
    logic [1:0]  port_rsp_valid_o;
    logic [1:0]  port_rsp_ready_i;
    logic        port_rsp_is_write_o;
    logic [31:0] port_rsp_data_o;
    logic        alloc_req_valid_o;
    logic        alloc_req_ready_i;
    logic        alloc_is_alloc_o;
    logic [31:0] alloc_addr_to_free_o;
    logic [31:0] alloc_size_to_allocate_o;
    logic        alloc_rsp_val_i;
    logic        alloc_rsp_is_write_i;
    logic [31:0] alloc_rsp_data_i;
    logic        alloc_rsp_ready_o;

    int checks = 0;
    int errors = 0;

    falafel_req_arbiter #(.NUM_PORTS(2), .FIFO_DEPTH(4)) dut (
        .clk_i                    (clk),
        .rst_i                    (rst_i),
        .port_req_valid_i         (port_req_valid_i),
        .port_req_ready_o         (port_req_ready_o),
        .port_req_is_alloc_i      (port_req_is_alloc_i),
        .port_req_data_i          (port_req_data_i),
        .port_rsp_valid_o         (port_rsp_valid_o),
        .port_rsp_ready_i         (port_rsp_ready_i),
        .port_rsp_is_write_o      (port_rsp_is_write_o),
        .port_rsp_data_o          (port_rsp_data_o),
        .alloc_req_valid_o        (alloc_req_valid_o),
        .alloc_req_ready_i        (alloc_req_ready_i),
        .alloc_is_alloc_o         (alloc_is_alloc_o),
        .alloc_addr_to_free_o     (alloc_addr_to_free_o),
        .alloc_size_to_allocate_o (alloc_size_to_allocate_o),
        .alloc_rsp_val_i          (alloc_rsp_val_i),
        .alloc_rsp_is_write_i     (alloc_rsp_is_write_i),
        .alloc_rsp_data_i         (alloc_rsp_data_i),
        .alloc_rsp_ready_o        (alloc_rsp_ready_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic [1:0]  req_valid;
        logic [1:0]  is_alloc;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        alloc_ready;
        logic        rsp_val;
        logic        rsp_wr;
        logic [31:0] rsp_data;
        logic [1:0]  rsp_ready;
        logic [1:0]  e_req_ready;
        logic        e_valid;
        logic        e_is_alloc;
        logic [31:0] e_size;
        logic [31:0] e_addr;
        logic        e_rsp_ready;
        logic [1:0]  e_prv;
        logic        e_pwr;
        logic [31:0] e_pdata;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        port_req_valid_i     = '0;
        port_req_is_alloc_i  = '0;
        port_req_data_i      = '0;
        port_rsp_ready_i     = '0;
        alloc_req_ready_i    = 1'b0;
        alloc_rsp_val_i      = 1'b0;
        alloc_rsp_is_write_i = 1'b0;
        alloc_rsp_data_i     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic wait_issue(input string nm);
        int n;
        n = 0;
        while (!alloc_req_valid_o && n < 20) begin
            tick();
            n++;
        end
        chk({nm, " issue_valid"}, 64'(alloc_req_valid_o), 64'd1);
    endtask

    // Full request/response round trip through the allocator for one expected request.
    task automatic serve(input string nm, input logic ia, input logic [31:0] d,
                         input logic [1:0] mask, input logic [31:0] rd);
        wait_issue(nm);
        chk({nm, " is_alloc"}, 64'(alloc_is_alloc_o), 64'(ia));
        chk({nm, " size"}, 64'(alloc_size_to_allocate_o), ia ? 64'(d) : 64'd0);
        chk({nm, " addr"}, 64'(alloc_addr_to_free_o), ia ? 64'd0 : 64'(d));
        alloc_req_ready_i = 1'b1;
        tick();
        alloc_req_ready_i = 1'b0;
        chk({nm, " rsp_ready"}, 64'(alloc_rsp_ready_o), 64'd1);
        chk({nm, " no_reissue"}, 64'(alloc_req_valid_o), 64'd0);
        alloc_rsp_val_i  = 1'b1;
        alloc_rsp_data_i = rd;
        tick();
        alloc_rsp_val_i  = 1'b0;
        chk({nm, " port_rsp_valid"}, 64'(port_rsp_valid_o), 64'(mask));
        chk({nm, " port_rsp_data"}, 64'(port_rsp_data_o), 64'(rd));
        port_rsp_ready_i = mask;
        tick();
        port_rsp_ready_i = '0;
        chk({nm, " rsp_done"}, 64'(port_rsp_valid_o), 64'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        idle_inputs();

        //          rst valid alloc d0        d1          ar rv wr rdata        rrdy  | ereq v  ia size      addr        rr prv pw pdata
        vecs[0]  = '{1, 2'b00, 2'b00, 32'h0,  32'h0,      0, 0, 0, 32'h0,      2'b00, 2'b11, 0, 0, 32'h0,  32'h0,      0, 2'b00, 0, 32'h0};
        vecs[1]  = '{0, 2'b01, 2'b01, 32'h40, 32'h0,      0, 0, 0, 32'h0,      2'b00, 2'b11, 0, 0, 32'h0,  32'h0,      0, 2'b00, 0, 32'h0};
        vecs[2]  = '{0, 2'b00, 2'b00, 32'h0,  32'h0,      0, 0, 0, 32'h0,      2'b00, 2'b11, 1, 1, 32'h40, 32'h0,      0, 2'b00, 0, 32'h0};
        vecs[3]  = '{0, 2'b00, 2'b00, 32'h0,  32'h0,      1, 0, 0, 32'h0,      2'b00, 2'b11, 0, 0, 32'h0,  32'h0,      1, 2'b00, 0, 32'h0};
        vecs[4]  = '{0, 2'b00, 2'b00, 32'h0,  32'h0,      0, 1, 0, 32'h1000,   2'b00, 2'b11, 0, 0, 32'h0,  32'h0,      0, 2'b01, 0, 32'h1000};
        vecs[5]  = '{0, 2'b00, 2'b00, 32'h0,  32'h0,      0, 0, 0, 32'h0,      2'b00, 2'b11, 0, 0, 32'h0,  32'h0,      0, 2'b01, 0, 32'h1000};
        vecs[6]  = '{0, 2'b00, 2'b00, 32'h0,  32'h0,      0, 0, 0, 32'h0,      2'b01, 2'b11, 0, 0, 32'h0,  32'h0,      0, 2'b00, 0, 32'h0};
        vecs[7]  = '{1, 2'b00, 2'b00, 32'h0,  32'h0,      0, 0, 0, 32'h0,      2'b00, 2'b11, 0, 0, 32'h0,  32'h0,      0, 2'b00, 0, 32'h0};
        vecs[8]  = '{0, 2'b11, 2'b01, 32'h10, 32'h2000,   0, 1, 1, 32'hDEAD,   2'b00, 2'b11, 0, 0, 32'h0,  32'h0,      0, 2'b00, 0, 32'h0};
        vecs[9]  = '{0, 2'b00, 2'b00, 32'h0,  32'h0,      0, 1, 1, 32'hBEEF,   2'b00, 2'b11, 1, 1, 32'h10, 32'h0,      0, 2'b00, 0, 32'h0};
        vecs[10] = '{0, 2'b00, 2'b00, 32'h0,  32'h0,      1, 0, 0, 32'h0,      2'b00, 2'b11, 0, 0, 32'h0,  32'h0,      1, 2'b00, 0, 32'h0};
        vecs[11] = '{0, 2'b00, 2'b00, 32'h0,  32'h0,      0, 1, 1, 32'hA0,     2'b00, 2'b11, 0, 0, 32'h0,  32'h0,      0, 2'b01, 1, 32'hA0};
        vecs[12] = '{0, 2'b00, 2'b00, 32'h0,  32'h0,      0, 0, 0, 32'h0,      2'b10, 2'b11, 0, 0, 32'h0,  32'h0,      0, 2'b01, 1, 32'hA0};
        vecs[13] = '{0, 2'b00, 2'b00, 32'h0,  32'h0,      0, 0, 0, 32'h0,      2'b01, 2'b11, 0, 0, 32'h0,  32'h0,      0, 2'b00, 0, 32'h0};
        vecs[14] = '{0, 2'b00, 2'b00, 32'h0,  32'h0,      0, 0, 0, 32'h0,      2'b00, 2'b11, 1, 0, 32'h0,  32'h2000,   0, 2'b00, 0, 32'h0};
        vecs[15] = '{0, 2'b00, 2'b00, 32'h0,  32'h0,      1, 0, 0, 32'h0,      2'b00, 2'b11, 0, 0, 32'h0,  32'h0,      1, 2'b00, 0, 32'h0};
        vecs[16] = '{0, 2'b00, 2'b00, 32'h0,  32'h0,      0, 1, 0, 32'h2000,   2'b00, 2'b11, 0, 0, 32'h0,  32'h0,      0, 2'b10, 0, 32'h2000};
        vecs[17] = '{0, 2'b00, 2'b00, 32'h0,  32'h0,      0, 0, 0, 32'h0,      2'b10, 2'b11, 0, 0, 32'h0,  32'h0,      0, 2'b00, 0, 32'h0};
        vecs[18] = '{0, 2'b00, 2'b00, 32'h0,  32'h0,      0, 1, 0, 32'h55,     2'b00, 2'b11, 0, 0, 32'h0,  32'h0,      0, 2'b00, 0, 32'h0};

        tick();
        for (int i = 0; i < 19; i++) begin
            rst_i                = vecs[i].rst;
            port_req_valid_i     = vecs[i].req_valid;
            port_req_is_alloc_i  = vecs[i].is_alloc;
            port_req_data_i      = {vecs[i].d1, vecs[i].d0};
            alloc_req_ready_i    = vecs[i].alloc_ready;
            alloc_rsp_val_i      = vecs[i].rsp_val;
            alloc_rsp_is_write_i = vecs[i].rsp_wr;
            alloc_rsp_data_i     = vecs[i].rsp_data;
            port_rsp_ready_i     = vecs[i].rsp_ready;
            tick();
            chk($sformatf("v%0d req_ready", i), 64'(port_req_ready_o), 64'(vecs[i].e_req_ready));
            chk($sformatf("v%0d req_valid", i), 64'(alloc_req_valid_o), 64'(vecs[i].e_valid));
            chk($sformatf("v%0d is_alloc", i), 64'(alloc_is_alloc_o), 64'(vecs[i].e_is_alloc));
            chk($sformatf("v%0d size", i), 64'(alloc_size_to_allocate_o), 64'(vecs[i].e_size));
            chk($sformatf("v%0d addr", i), 64'(alloc_addr_to_free_o), 64'(vecs[i].e_addr));
            chk($sformatf("v%0d rsp_ready", i), 64'(alloc_rsp_ready_o), 64'(vecs[i].e_rsp_ready));
            chk($sformatf("v%0d port_rsp_valid", i), 64'(port_rsp_valid_o), 64'(vecs[i].e_prv));
            chk($sformatf("v%0d port_rsp_wr", i), 64'(port_rsp_is_write_o), 64'(vecs[i].e_pwr));
            chk($sformatf("v%0d port_rsp_data", i), 64'(port_rsp_data_o), 64'(vecs[i].e_pdata));
        end

        // Fill port1 while port0's request is stuck at the allocator.
        do_reset();
        port_req_valid_i      = 2'b01;
        port_req_is_alloc_i   = 2'b01;
        port_req_data_i[31:0] = 32'h50;
        tick();
        idle_inputs();
        wait_issue("fill_p0");
        for (int k = 0; k < 4; k++) begin
            port_req_valid_i       = 2'b10;
            port_req_is_alloc_i[1] = k[0];
            port_req_data_i[63:32] = 32'h101 + 32'(k);
            tick();
            chk($sformatf("fill ready1 after push%0d", k + 1), 64'(port_req_ready_o[1]), (k < 3) ? 64'd1 : 64'd0);
        end
        port_req_is_alloc_i[1] = 1'b0;
        port_req_data_i[63:32] = 32'h105;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fill ready1 held low", 64'(port_req_ready_o[1]), 64'd0);
        end
        idle_inputs();
        serve("fill_p0_serve", 1'b1, 32'h50, 2'b01, 32'h9000);
        for (int k = 0; k < 4; k++) begin
            serve($sformatf("fill_p1_e%0d", k), k[0], 32'h101 + 32'(k), 2'b10, 32'hA000 + 32'(k));
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fill no fifth", 64'(alloc_req_valid_o), 64'd0);
        end
        chk("fill ready restored", 64'(port_req_ready_o), 64'd3);

        // Backpressure on both the allocator request and the client response.
        do_reset();
        port_req_valid_i      = 2'b01;
        port_req_is_alloc_i   = 2'b01;
        port_req_data_i[31:0] = 32'h77;
        tick();
        idle_inputs();
        wait_issue("bp");
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp req held valid", 64'(alloc_req_valid_o), 64'd1);
            chk("bp req held size", 64'(alloc_size_to_allocate_o), 64'h77);
        end
        alloc_req_ready_i = 1'b1;
        tick();
        alloc_req_ready_i = 1'b0;
        chk("bp single issue", 64'(alloc_req_valid_o), 64'd0);
        tick();
        chk("bp wait rsp_ready", 64'(alloc_rsp_ready_o), 64'd1);
        chk("bp no reissue", 64'(alloc_req_valid_o), 64'd0);
        alloc_rsp_val_i  = 1'b1;
        alloc_rsp_data_i = 32'h3000;
        tick();
        alloc_rsp_val_i  = 1'b0;
        alloc_rsp_data_i = 32'h0;
        for (int k = 0; k < 3; k++) begin
            chk("bp rsp held valid", 64'(port_rsp_valid_o), 64'd1);
            chk("bp rsp held data", 64'(port_rsp_data_o), 64'h3000);
            tick();
        end
        port_rsp_ready_i = 2'b01;
        tick();
        port_rsp_ready_i = 2'b00;
        for (int k = 0; k < 3; k++) begin
            chk("bp no dup rsp", 64'(port_rsp_valid_o), 64'd0);
            chk("bp no dup req", 64'(alloc_req_valid_o), 64'd0);
            tick();
        end

        // Asynchronous reset while waiting on the allocator with two entries queued.
        do_reset();
        port_req_valid_i      = 2'b01;
        port_req_is_alloc_i   = 2'b01;
        port_req_data_i[31:0] = 32'h20;
        tick();
        idle_inputs();
        wait_issue("rst");
        alloc_req_ready_i = 1'b1;
        tick();
        alloc_req_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            port_req_valid_i       = 2'b10;
            port_req_data_i[63:32] = 32'h200 + 32'(k);
            tick();
        end
        idle_inputs();
        chk("rst in wait_rsp", 64'(alloc_rsp_ready_o), 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst async rsp_ready", 64'(alloc_rsp_ready_o), 64'd0);
        chk("rst async req_valid", 64'(alloc_req_valid_o), 64'd0);
        chk("rst async port_rsp", 64'(port_rsp_valid_o), 64'd0);
        chk("rst async req_ready", 64'(port_req_ready_o), 64'd3);
        tick();
        rst_i            = 1'b0;
        alloc_rsp_val_i  = 1'b1;
        alloc_rsp_data_i = 32'h5555;
        tick();
        idle_inputs();
        for (int k = 0; k < 6; k++) begin
            chk("rst no response", 64'(port_rsp_valid_o), 64'd0);
            chk("rst queues empty", 64'(alloc_req_valid_o), 64'd0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
